// File: rtl/types_def.sv
// Types shared by the bank queue scheduler: request format, queue index width
// and the burst scheduler states.
package types_def;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } r_type;

  typedef struct packed {
    r_type       req_type;
    logic [15:0] addr;
  } opt_request;

  localparam int READ_ENTRIES = 8;
  typedef logic [$clog2(READ_ENTRIES)-1:0] read_entries_log;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after ptr, wrapping.
// A masked and an unmasked lowest-bit priority encoder cover both halves of the ring.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (PTR_W'(i) >= ptr);
    end
    masked = req & mask;
    // Isolate the lowest set bit; fall back to the full set once the masked half is empty.
    if (|masked) begin
      gnt = masked & (~masked + N'(1));
    end else begin
      gnt = req & (~req + N'(1));
    end
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (gnt[i]) idx = PTR_W'(i);
    end
  end

endmodule

// File: rtl/bank_queue_scheduler.sv
// Shares one downstream command slot between NUM_Q bank queues, grouping requests
// into read/write bursts with a shared round-robin pointer and a burst-length cap.
module bank_queue_scheduler
  import types_def::*;
#(
  parameter int NUM_Q     = 4,
  parameter int MAX_BURST = 4,
  parameter int Q_LOG     = $clog2(NUM_Q)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  opt_request      request_i [NUM_Q],
  input  read_entries_log index_i   [NUM_Q],
  input  logic [NUM_Q-1:0] valid_i,
  output logic [NUM_Q-1:0] grant_o,
  output opt_request      request_o,
  output read_entries_log index_o,
  output logic [Q_LOG-1:0] queue_o,
  output logic            valid_o,
  input  logic            grant_i
);

  localparam logic [3:0] CAP = 4'(MAX_BURST);

  sched_state_t    state_q, state_d;
  logic [3:0]      burst_cnt_q, burst_cnt_d;
  logic [Q_LOG-1:0] rr_ptr_q, rr_ptr_d;
  logic            valid_q, valid_d;
  opt_request      request_q, request_d;
  read_entries_log index_q, index_d;
  logic [Q_LOG-1:0] queue_q, queue_d;

  logic [NUM_Q-1:0] e_rd, e_wr, rd_gnt, wr_gnt, grant_vec;
  logic [Q_LOG-1:0] rd_idx, wr_idx, win_idx;
  logic             rd_any, wr_any, slot_free, take_rd, take_wr;

  always_comb begin
    e_rd = '0;
    e_wr = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      e_rd[i] = valid_i[i] && (request_i[i].req_type == READ);
      e_wr[i] = valid_i[i] && (request_i[i].req_type == WRITE);
    end
  end

  rr_arbiter #(.N(NUM_Q), .PTR_W(Q_LOG)) u_rd_arb (
    .req (e_rd),
    .ptr (rr_ptr_q),
    .gnt (rd_gnt),
    .idx (rd_idx),
    .any (rd_any)
  );

  rr_arbiter #(.N(NUM_Q), .PTR_W(Q_LOG)) u_wr_arb (
    .req (e_wr),
    .ptr (rr_ptr_q),
    .gnt (wr_gnt),
    .idx (wr_idx),
    .any (wr_any)
  );

  assign slot_free = !valid_q || grant_i;

  // Burst FSM: stay on a type until the cap, switch only if the other type waits.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    take_rd     = 1'b0;
    take_wr     = 1'b0;
    if (slot_free) begin
      case (state_q)
        RD_BURST: begin
          if (rd_any && burst_cnt_q < CAP) begin
            take_rd     = 1'b1;
            burst_cnt_d = burst_cnt_q + 4'd1;
          end else if (wr_any) begin
            take_wr     = 1'b1;
            state_d     = WR_BURST;
            burst_cnt_d = 4'd1;
          end else if (rd_any) begin
            take_rd     = 1'b1;
            burst_cnt_d = 4'd1;
          end else begin
            state_d     = IDLE;
            burst_cnt_d = 4'd0;
          end
        end
        WR_BURST: begin
          if (wr_any && burst_cnt_q < CAP) begin
            take_wr     = 1'b1;
            burst_cnt_d = burst_cnt_q + 4'd1;
          end else if (rd_any) begin
            take_rd     = 1'b1;
            state_d     = RD_BURST;
            burst_cnt_d = 4'd1;
          end else if (wr_any) begin
            take_wr     = 1'b1;
            burst_cnt_d = 4'd1;
          end else begin
            state_d     = IDLE;
            burst_cnt_d = 4'd0;
          end
        end
        default: begin
          if (rd_any) begin
            take_rd     = 1'b1;
            state_d     = RD_BURST;
            burst_cnt_d = 4'd1;
          end else if (wr_any) begin
            take_wr     = 1'b1;
            state_d     = WR_BURST;
            burst_cnt_d = 4'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    grant_vec = take_rd ? rd_gnt : (take_wr ? wr_gnt : '0);
    win_idx   = take_rd ? rd_idx : wr_idx;
    valid_d   = valid_q;
    request_d = request_q;
    index_d   = index_q;
    queue_d   = queue_q;
    rr_ptr_d  = rr_ptr_q;
    if (slot_free) begin
      valid_d = take_rd || take_wr;
      if (take_rd || take_wr) begin
        request_d = request_i[win_idx];
        index_d   = index_i[win_idx];
        queue_d   = win_idx;
        rr_ptr_d  = (win_idx == Q_LOG'(NUM_Q - 1)) ? '0 : win_idx + Q_LOG'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      rr_ptr_q    <= '0;
      valid_q     <= 1'b0;
      request_q   <= '0;
      index_q     <= '0;
      queue_q     <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      valid_q     <= valid_d;
      request_q   <= request_d;
      index_q     <= index_d;
      queue_q     <= queue_d;
    end
  end

  // Pop grants are suppressed while reset is held so queues never lose a head.
  assign grant_o   = rst_n ? grant_vec : '0;
  assign valid_o   = valid_q;
  assign request_o = request_q;
  assign index_o   = index_q;
  assign queue_o   = queue_q;

endmodule

// File: tb/tb_bank_queue_scheduler.sv
// Bench for bank_queue_scheduler: directed scenarios plus a randomized run
// compared against a rule-level reference model.
module tb_bank_queue_scheduler;
  import types_def::*;

  localparam int NQ   = 4;
  localparam int MAXB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  opt_request      request_i [NQ];
  read_entries_log index_i   [NQ];
  logic [NQ-1:0]   valid_i;
  logic [NQ-1:0]   grant_o;
  opt_request      request_o;
  read_entries_log index_o;
  logic [1:0]      queue_o;
  logic            valid_o;
  logic            grant_i;

  int checks = 0;
  int failures = 0;

  bank_queue_scheduler #(.NUM_Q(NQ), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .request_i (request_i),
    .index_i   (index_i),
    .valid_i   (valid_i),
    .grant_o   (grant_o),
    .request_o (request_o),
    .index_o   (index_o),
    .queue_o   (queue_o),
    .valid_o   (valid_o),
    .grant_i   (grant_i)
  );

  always #5 clk = ~clk;

  task automatic set_q(input int q, input r_type t, input int idx, input int addr);
    request_i[q].req_type = t;
    request_i[q].addr     = 16'(addr);
    index_i[q]            = read_entries_log'(idx);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    valid_i = '0;
    grant_i = 1'b0;
    for (int i = 0; i < NQ; i++) set_q(i, READ, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int pick(input logic [NQ-1:0] set, input int ptr);
    for (int k = 0; k < NQ; k++) begin
      if (set[(ptr + k) % NQ]) return (ptr + k) % NQ;
    end
    return -1;
  endfunction

  function automatic sched_state_t st_of(input int s);
    if (s == 1) return RD_BURST;
    if (s == 2) return WR_BURST;
    return IDLE;
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    grant_i = 1'b1;
    valid_i = 4'b1111;
    for (int i = 0; i < NQ; i++) set_q(i, READ, i, 16'h10 + i);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (grant_o !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b want=0000", grant_o); end
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b1) begin failures++; $display("FAIL reset_release_valid got=%b want=1", valid_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || dut.state_q !== IDLE) begin
      failures++; $display("FAIL async_reset valid=%b state=%0d want valid=0 state=0", valid_o, dut.state_q);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    set_q(2, READ, 5, 16'h2222);
    valid_i = 4'b0100;
    grant_i = 1'b1;
    #1;
    checks++;
    if (grant_o !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b want=0100", grant_o); end
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b1 || queue_o !== 2'd2 || index_o !== 3'd5 || dut.state_q !== RD_BURST) begin
      failures++;
      $display("FAIL single_slot valid=%b q=%0d idx=%0d state=%0d want 1 2 5 1", valid_o, queue_o, index_o, dut.state_q);
    end
  endtask

  task automatic test_round_robin();
    int exp_q [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < NQ; i++) set_q(i, READ, i, 16'h100 + i);
    valid_i = 4'b1111;
    grant_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checks++;
      if (valid_o !== 1'b1 || queue_o !== 2'(exp_q[k])) begin
        failures++; $display("FAIL rr_seq[%0d] q=%0d v=%b want q=%0d", k, queue_o, valid_o, exp_q[k]);
      end
      if (k == 3) begin
        checks++;
        if (dut.burst_cnt_q !== 4'd4) begin failures++; $display("FAIL rr_cnt_cap got=%0d want=4", dut.burst_cnt_q); end
      end
      if (k == 4) begin
        checks++;
        if (dut.burst_cnt_q !== 4'd1 || dut.state_q !== RD_BURST) begin
          failures++; $display("FAIL rr_rule_c cnt=%0d state=%0d want 1 1", dut.burst_cnt_q, dut.state_q);
        end
      end
    end
  endtask

  task automatic test_burst_cap();
    int exp_q [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    do_reset();
    set_q(0, READ, 1, 16'hA0);
    set_q(1, WRITE, 2, 16'hB1);
    valid_i = 4'b0011;
    grant_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      checks++;
      if (valid_o !== 1'b1 || queue_o !== 2'(exp_q[k])) begin
        failures++; $display("FAIL cap_seq[%0d] q=%0d v=%b want q=%0d", k, queue_o, valid_o, exp_q[k]);
      end
      if (k == 3 || k == 4 || k == 8) begin
        checks++;
        if (dut.state_q !== ((k == 4) ? WR_BURST : RD_BURST)) begin
          failures++; $display("FAIL cap_state[%0d] got=%0d", k, dut.state_q);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < NQ; i++) set_q(i, READ, i, 16'h100 + i);
    valid_i = 4'b1111;
    grant_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (queue_o !== 2'd3) begin failures++; $display("FAIL bp_load q=%0d want=3", queue_o); end
    grant_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (grant_o !== 4'b0000) begin failures++; $display("FAIL bp_grant[%0d] got=%b want=0000", k, grant_o); end
      @(posedge clk); #1;
      checks++;
      if (valid_o !== 1'b1 || queue_o !== 2'd3 || request_o.addr !== 16'h103) begin
        failures++; $display("FAIL bp_hold[%0d] v=%b q=%0d addr=%h want 1 3 0103", k, valid_o, queue_o, request_o.addr);
      end
    end
    grant_i = 1'b1;
    #1;
    checks++;
    if (grant_o !== 4'b0001) begin failures++; $display("FAIL bp_release_grant got=%b want=0001", grant_o); end
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b1 || queue_o !== 2'd0) begin
      failures++; $display("FAIL bp_no_bubble v=%b q=%0d want 1 0", valid_o, queue_o);
    end
  endtask

  task automatic test_drain();
    do_reset();
    set_q(2, READ, 3, 16'h0C2);
    valid_i = 4'b0100;
    grant_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 4'b0000;
    #1;
    checks++;
    if (grant_o !== 4'b0000) begin failures++; $display("FAIL drain_grant got=%b want=0000", grant_o); end
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b0 || dut.state_q !== IDLE || dut.burst_cnt_q !== 4'd0) begin
      failures++; $display("FAIL drain_idle v=%b state=%0d cnt=%0d want 0 0 0", valid_o, dut.state_q, dut.burst_cnt_q);
    end
    set_q(1, WRITE, 6, 16'h0D1);
    valid_i = 4'b0010;
    #1;
    checks++;
    if (grant_o !== 4'b0010) begin failures++; $display("FAIL drain_wr_grant got=%b want=0010", grant_o); end
    @(posedge clk); #1;
    checks++;
    if (dut.state_q !== WR_BURST || queue_o !== 2'd1 || valid_o !== 1'b1) begin
      failures++; $display("FAIL drain_wr state=%0d q=%0d v=%b want 2 1 1", dut.state_q, queue_o, valid_o);
    end
  endtask

  task automatic test_random();
    int m_state, m_cnt, m_ptr, m_q;
    bit m_vld, free;
    opt_request m_req;
    read_entries_log m_idx;
    logic [NQ-1:0] erd, ewr, exp_g;
    int rd, wr, own, oth, win, nst, ncnt;
    do_reset();
    m_state = 0; m_cnt = 0; m_ptr = 0; m_q = 0; m_vld = 0;
    m_req = '0; m_idx = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NQ; i++) begin
        set_q(i, r_type'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 65535));
      end
      valid_i = 4'($urandom_range(0, 15));
      grant_i = ($urandom_range(0, 3) != 0);
      #1;
      erd = '0; ewr = '0;
      for (int i = 0; i < NQ; i++) begin
        erd[i] = valid_i[i] && request_i[i].req_type == READ;
        ewr[i] = valid_i[i] && request_i[i].req_type == WRITE;
      end
      free = !m_vld || grant_i;
      win = -1; nst = m_state; ncnt = m_cnt;
      if (free) begin
        rd = pick(erd, m_ptr);
        wr = pick(ewr, m_ptr);
        if (m_state == 0) begin
          if (rd >= 0) begin win = rd; nst = 1; ncnt = 1; end
          else if (wr >= 0) begin win = wr; nst = 2; ncnt = 1; end
        end else begin
          own = (m_state == 1) ? rd : wr;
          oth = (m_state == 1) ? wr : rd;
          if (own >= 0 && m_cnt < MAXB) begin win = own; ncnt = m_cnt + 1; end
          else if (oth >= 0) begin win = oth; nst = 3 - m_state; ncnt = 1; end
          else if (own >= 0) begin win = own; ncnt = 1; end
          else begin nst = 0; ncnt = 0; end
        end
      end
      exp_g = (win >= 0) ? (4'b0001 << win) : 4'b0000;
      checks++;
      if (grant_o !== exp_g) begin failures++; $display("FAIL rnd_grant[%0d] got=%b want=%b", cyc, grant_o, exp_g); end
      if (free) begin
        m_vld = (win >= 0);
        if (win >= 0) begin
          m_req = request_i[win]; m_idx = index_i[win]; m_q = win; m_ptr = (win + 1) % NQ;
        end
      end
      m_state = nst; m_cnt = ncnt;
      @(posedge clk); #1;
      checks++;
      if (valid_o !== m_vld || dut.state_q !== st_of(m_state) || dut.burst_cnt_q !== 4'(m_cnt)) begin
        failures++;
        $display("FAIL rnd_ctrl[%0d] v=%b st=%0d cnt=%0d want v=%b st=%0d cnt=%0d",
                 cyc, valid_o, dut.state_q, dut.burst_cnt_q, m_vld, m_state, m_cnt);
      end
      if (m_vld) begin
        checks++;
        if (queue_o !== 2'(m_q) || index_o !== m_idx || request_o !== m_req) begin
          failures++;
          $display("FAIL rnd_slot[%0d] q=%0d idx=%0d req=%h want q=%0d idx=%0d req=%h",
                   cyc, queue_o, index_o, request_o, m_q, m_idx, m_req);
        end
      end
    end
  endtask

  initial begin
    valid_i = '0;
    grant_i = 1'b0;
    for (int i = 0; i < NQ; i++) set_q(i, READ, 0, 0);
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bank_queue_scheduler.md
Name: bank_queue_scheduler

Overview:
- Shares one downstream command port between NUM_Q per-bank request queues. Each queue is a front-end FIFO exposing its head request through a valid/grant pop side.
- Groups requests into same-type bursts (read or write) to cut bus turnaround. Arbitrates round-robin inside a type and caps burst length for fairness.
- Sits between the bank queues and the command scheduler. Provides one registered output slot with a valid/grant handshake.

Parameters:
- NUM_Q, 4, number of queues served. Legal range 2..16.
- MAX_BURST, 4, maximum consecutive grants of one type before a switch is forced if the other type is pending. Legal range 1..15.
- Q_LOG, $clog2(NUM_Q), width of the queue id.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- request_i  in  NUM_Q x opt_request  head request of each queue.
- index_i  in  NUM_Q x read_entries_log  head index of each queue.
- valid_i  in  NUM_Q  head valid of each queue.
- grant_o  out  NUM_Q  one-hot pop grant to the queues.
- request_o  out  opt_request  selected request.
- index_o  out  read_entries_log  selected index.
- queue_o  out  Q_LOG  id of the queue that supplied the request.
- valid_o  out  1  output slot holds a request.
- grant_i  in  1  downstream accepts the slot this cycle.

Behaviour:
- Reset and clocking:
  - Single clock domain. One clock, clk; asynchronous active-low reset, rst_n.
  - On reset assertion, immediately and regardless of clk: valid_o=0, request_o=0, index_o=0, queue_o=0, state=IDLE, rr_ptr=0, burst_cnt=0. grant_o=0 while rst_n=0.
- Definitions:
  - slot_free = !valid_o || grant_i.
  - E_RD = valid_i where request_i.req_type==read; E_WR = valid_i where request_i.req_type==write.
  - Winner of a set = first set bit at or after rr_ptr, wrapping modulo NUM_Q.
- Outputs:
  - grant_o is combinational. It is all-zero unless slot_free, and has at most one bit set.
  - A granted request is registered into the slot on the same edge, so valid_o rises 1 cycle after grant. This gives 1-cycle latency from head-valid to valid_o.
  - While valid_o=1 and grant_i=0: the slot contents, state, rr_ptr and burst_cnt hold and grant_o=0.
  - If slot_free and no grant is issued: valid_o falls at the next edge (when grant_i=1) or stays 0.
- State machine: states IDLE, RD_BURST, WR_BURST. Evaluation happens only when slot_free.
  - IDLE: if E_RD is non-empty, grant the E_RD winner, go to RD_BURST, burst_cnt=1. Else if E_WR is non-empty, grant the E_WR winner, go to WR_BURST, burst_cnt=1. Else stay in IDLE.
  - RD_BURST or WR_BURST, own type T, other type O, applied in priority order:
    - (a) E_T non-empty and burst_cnt<MAX_BURST: grant the E_T winner, burst_cnt+1.
    - (b) E_O non-empty: switch to the O burst state, grant the E_O winner, burst_cnt=1.
    - (c) E_T non-empty (cap reached, no other type pending): grant the E_T winner, burst_cnt=1, stay in the state.
    - (d) No valid_i at all: go to IDLE, burst_cnt=0.
- Round-robin pointer:
  - On every grant, rr_ptr = winner+1, with NUM_Q-1 wrapping to 0.
  - A single pointer is shared by both types.
- Widths and counter:
  - burst_cnt is 4 bits and never exceeds MAX_BURST.
- Input assumptions:
  - The queues' valid_i does not depend on grant_o combinationally, so there is no loop.
  - valid_i may drop without a grant. Arbitration samples only the current cycle.
  - Simultaneous grant_i and a new grant: the slot is replaced on the same edge with no bubble.

Decomposition:
- Package types_def holds the shared types and constants.
  - Existing: r_type, opt_request, read_entries_log.
  - Add: sched_state_t enum {IDLE, RD_BURST, WR_BURST}.
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; outputs one-hot gnt[N], idx, any. Implemented with the mask/unmasked double priority encoder.
  - Two instances, one for E_RD and one for E_WR, share rr_ptr. The FSM picks which instance to use.

Test Plan:
- Reset: hold rst_n=0 with valid_i=4'b1111 -> grant_o=0, valid_o=0. Assert rst_n=0 asynchronously mid-burst -> valid_o=0 before the next edge.
- Single read: valid_i=4'b0100 read, index_i[2]=5, grant_i=1 -> grant_o=4'b0100 the same cycle; the next cycle valid_o=1, queue_o=2, index_o=5, state=RD_BURST.
- Round-robin: all 4 queues issue continuous reads, grant_i=1 -> queue_o sequence 0,1,2,3,0,1. With MAX_BURST=4, rule (c) resets the count with no type change.
- Burst cap: queue0 continuous reads, queue1 continuous writes -> queue_o sequence 0,0,0,0,1,1,1,1,0; the state toggles after every 4 grants.
- Backpressure: slot holds queue 3, grant_i=0 for 3 cycles with valid_i=4'b1111 -> grant_o=0, request_o/queue_o stable. With grant_i=1 on cycle 4, the next winner loads with no bubble.
- Drain to idle: the last request is accepted with no valid_i -> valid_o=0 the next cycle, state=IDLE, burst_cnt=0. A later write on queue 1 -> WR_BURST.
